picaso_array_pipe: RTL

- Parametrised successor of the PiCaSO block array.
- Instantiates an ARR_ROW_CNT x ARR_COL_CNT grid of picaso_ff blocks.
- Drives the broadcast control bundle through a configurable, reset-clearable register pipeline, so large tiles close timing.
- Collects each row's west-edge serial result stream into OUT_WIDTH-bit words, presented on a per-row valid/ready port with overflow detection; sits between the PiCaSO controller and the tile output logic.

---
 rtl/picaso_array_pipe.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/picaso_array_pipe.sv
// PiCaSO block array with a reset-clearable control broadcast pipeline and per-row output word collection.
// Build option: PICASO_ARRAY_PIPE_MSB_FIRST_EN collects the row streams MSB-first instead of LSB-first.

module picaso_ff #(
  parameter int DEBUG            = 1,
  parameter int NET_STREAM_WIDTH = 1,
  parameter int MAX_NET_LEVEL    = 3,
  parameter int ID_WIDTH         = 8,
  parameter int PE_CNT           = 16,
  parameter int RF_DEPTH         = 1024,
  parameter int ROW_ID           = 0,
  parameter int COL_ID           = 0,
  localparam int LVL_W  = $clog2(MAX_NET_LEVEL + 1),
  localparam int ADDR_W = $clog2(RF_DEPTH)
) (
  input  logic                        clk,
  input  logic                        dbg_clk_enable,
  input  logic [LVL_W-1:0]            netLevel,
  input  logic                        netConfLoad,
  input  logic                        netCaptureEn,
  input  logic [1:0]                  aluConf,
  input  logic                        aluConfLoad,
  input  logic                        aluEn,
  input  logic                        aluReset,
  input  logic                        aluMbitReset,
  input  logic                        aluMbitLoad,
  input  logic                        opmuxConfLoad,
  input  logic [1:0]                  opmuxConf,
  input  logic                        opmuxEn,
  input  logic                        extDataSave,
  input  logic [PE_CNT-1:0]           extDataIn,
  input  logic                        saveAluOut,
  input  logic [ADDR_W-1:0]           addrA,
  input  logic [ADDR_W-1:0]           addrB,
  input  logic [ID_WIDTH-1:0]         selRow,
  input  logic [ID_WIDTH-1:0]         selCol,
  input  logic [1:0]                  selMode,
  input  logic                        selEn,
  input  logic                        selOp,
  input  logic                        ptrLoad,
  input  logic                        ptrIncr,
  input  logic [NET_STREAM_WIDTH-1:0] eastIn,
  output logic                        westOut,
  output logic                        serialOut,
  output logic                        serialOutValid
);
  logic [PE_CNT-1:0] rf [RF_DEPTH];
  logic [PE_CNT-1:0] rd_a_reg, rd_b_reg, acc_reg, mbit_reg, op_a, alu_res;
  logic [ADDR_W-1:0] ptr_reg;
  logic [LVL_W-1:0]  net_lvl_reg;
  logic [1:0]        alu_conf_reg, opmux_conf_reg;
  logic              sel_reg, sel_match;

  always_comb begin
    op_a = rd_a_reg;
    if (opmuxEn) begin
      case (opmux_conf_reg)
        2'd0: op_a = rd_a_reg;
        2'd1: op_a = ~rd_a_reg;
        2'd2: op_a = rd_b_reg;
        default: op_a = '0;
      endcase
    end
    case (alu_conf_reg)
      2'd0: alu_res = op_a + rd_b_reg;
      2'd1: alu_res = op_a - rd_b_reg;
      2'd2: alu_res = op_a & rd_b_reg;
      default: alu_res = op_a | rd_b_reg;
    endcase
    case (selMode)
      2'd0: sel_match = 1'b1;
      2'd1: sel_match = (selRow == ID_WIDTH'(ROW_ID));
      2'd2: sel_match = (selCol == ID_WIDTH'(COL_ID));
      default: sel_match = (selRow == ID_WIDTH'(ROW_ID)) && (selCol == ID_WIDTH'(COL_ID));
    endcase
  end

  // Register file with registered read ports; ALU ops consume the data one cycle after the address.
  always_ff @(posedge clk) begin
    rd_a_reg <= rf[addrA];
    rd_b_reg <= rf[addrB];
    if (extDataSave) rf[addrA] <= extDataIn;
    else if (saveAluOut && sel_reg) rf[ptr_reg] <= acc_reg;
    if (netConfLoad) net_lvl_reg <= netLevel;
    if (aluConfLoad) alu_conf_reg <= aluConf;
    if (opmuxConfLoad) opmux_conf_reg <= opmuxConf;
    if (aluReset) acc_reg <= '0;
    else if (aluEn) acc_reg <= alu_res;
    if (aluMbitReset) mbit_reg <= '0;
    else if (aluMbitLoad) mbit_reg <= acc_reg;
    else if (netCaptureEn && net_lvl_reg != '0) mbit_reg <= {eastIn[0], mbit_reg[PE_CNT-1:1]};
    if (ptrLoad) ptr_reg <= addrB;
    else if (ptrIncr) ptr_reg <= ptr_reg + 1'b1;
    if (selEn) sel_reg <= selOp ? (sel_reg | sel_match) : (sel_reg & ~sel_match);
  end

  // Level 0 is a straight pass-through of the east stream; other levels shift out the result word.
  assign westOut        = (net_lvl_reg == '0) ? eastIn[0] : mbit_reg[0];
  assign serialOut      = westOut;
  assign serialOutValid = netCaptureEn & (dbg_clk_enable | (DEBUG == 0));
endmodule

module picaso_array_pipe #(
  parameter int DEBUG            = 1,
  parameter int ARR_ROW_CNT      = 4,
  parameter int ARR_COL_CNT      = 4,
  parameter int START_ROW_ID     = 0,
  parameter int START_COL_ID     = 0,
  parameter int NET_STREAM_WIDTH = 1,
  parameter int MAX_NET_LEVEL    = 3,
  parameter int ID_WIDTH         = 8,
  parameter int PE_CNT           = 16,
  parameter int RF_DEPTH         = 1024,
  parameter int CTRL_PIPE_STAGES = 2,
  parameter int OUT_WIDTH        = 16,
  localparam int LVL_W  = $clog2(MAX_NET_LEVEL + 1),
  localparam int ADDR_W = $clog2(RF_DEPTH),
  localparam int CTRL_W = LVL_W + 2*ADDR_W + 2*ID_WIDTH + PE_CNT + 21,
  localparam int CNT_W  = $clog2(OUT_WIDTH)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [CTRL_W-1:0]                ctrlIn,
  input  logic [ARR_ROW_CNT-1:0]           eastIn,
  output logic [ARR_ROW_CNT-1:0]           westOut,
  input  logic                             desClear,
  output logic [ARR_ROW_CNT*OUT_WIDTH-1:0] rowData,
  output logic [ARR_ROW_CNT-1:0]           rowValid,
  input  logic [ARR_ROW_CNT-1:0]           rowReady,
  output logic [ARR_ROW_CNT-1:0]           rowOverflow
);
  typedef struct packed {
    logic [LVL_W-1:0] netLevel;    logic netConfLoad;   logic netCaptureEn;
    logic [1:0] aluConf;           logic aluConfLoad;   logic aluEn;
    logic aluReset;                logic aluMbitReset;  logic aluMbitLoad;
    logic opmuxConfLoad;           logic [1:0] opmuxConf; logic opmuxEn;
    logic extDataSave;             logic [PE_CNT-1:0] extDataIn; logic saveAluOut;
    logic [ADDR_W-1:0] addrA;      logic [ADDR_W-1:0] addrB;
    logic [ID_WIDTH-1:0] selRow;   logic [ID_WIDTH-1:0] selCol;
    logic [1:0] selMode;           logic selEn;         logic selOp;
    logic ptrLoad;                 logic ptrIncr;
  } ctrl_t;

  logic [CTRL_W-1:0] ctrl_bcast;
  ctrl_t             ctrl_b;
  logic [ARR_ROW_CNT-1:0][ARR_COL_CNT:0]   link;
  logic [ARR_ROW_CNT-1:0][ARR_COL_CNT-1:0] ser_bit, ser_vld;
  logic              unused_taps;

  generate
    if (CTRL_PIPE_STAGES == 0) begin : g_no_pipe
      assign ctrl_bcast = ctrlIn;
    end else begin : g_pipe
      logic [CTRL_W-1:0] pipe_reg [CTRL_PIPE_STAGES];
      // Reset clears every stage so in-flight commands turn into NOPs.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < CTRL_PIPE_STAGES; i++) pipe_reg[i] <= '0;
        end else begin
          pipe_reg[0] <= ctrlIn;
          for (int i = 1; i < CTRL_PIPE_STAGES; i++) pipe_reg[i] <= pipe_reg[i-1];
        end
      end
      assign ctrl_bcast = pipe_reg[CTRL_PIPE_STAGES-1];
    end
  endgenerate

  assign ctrl_b      = ctrl_bcast;
  assign unused_taps = ^{ser_bit, ser_vld};

  genvar gi, gc;
  generate
    for (gi = 0; gi < ARR_ROW_CNT; gi++) begin : g_row
      assign link[gi][ARR_COL_CNT] = eastIn[gi];
      assign westOut[gi]           = link[gi][0];

      for (gc = 0; gc < ARR_COL_CNT; gc++) begin : g_col
        picaso_ff #(
          .DEBUG(DEBUG), .NET_STREAM_WIDTH(NET_STREAM_WIDTH), .MAX_NET_LEVEL(MAX_NET_LEVEL),
          .ID_WIDTH(ID_WIDTH), .PE_CNT(PE_CNT), .RF_DEPTH(RF_DEPTH),
          .ROW_ID(START_ROW_ID + gi), .COL_ID(START_COL_ID + gc)
        ) u_blk (
          .clk(clk), .dbg_clk_enable(1'b1),
          .netLevel(ctrl_b.netLevel), .netConfLoad(ctrl_b.netConfLoad), .netCaptureEn(ctrl_b.netCaptureEn),
          .aluConf(ctrl_b.aluConf), .aluConfLoad(ctrl_b.aluConfLoad), .aluEn(ctrl_b.aluEn),
          .aluReset(ctrl_b.aluReset), .aluMbitReset(ctrl_b.aluMbitReset), .aluMbitLoad(ctrl_b.aluMbitLoad),
          .opmuxConfLoad(ctrl_b.opmuxConfLoad), .opmuxConf(ctrl_b.opmuxConf), .opmuxEn(ctrl_b.opmuxEn),
          .extDataSave(ctrl_b.extDataSave), .extDataIn(ctrl_b.extDataIn), .saveAluOut(ctrl_b.saveAluOut),
          .addrA(ctrl_b.addrA), .addrB(ctrl_b.addrB), .selRow(ctrl_b.selRow), .selCol(ctrl_b.selCol),
          .selMode(ctrl_b.selMode), .selEn(ctrl_b.selEn), .selOp(ctrl_b.selOp),
          .ptrLoad(ctrl_b.ptrLoad), .ptrIncr(ctrl_b.ptrIncr),
          .eastIn(link[gi][gc+1]), .westOut(link[gi][gc]),
          .serialOut(ser_bit[gi][gc]), .serialOutValid(ser_vld[gi][gc])
        );
      end

      logic [CNT_W-1:0]     cnt_reg, bit_idx;
      logic [OUT_WIDTH-1:0] word_reg, word_next, data_reg;
      logic                 valid_reg, ovf_reg, bit_vld, last;

      assign bit_vld = ser_vld[gi][0];
      assign last    = bit_vld && (cnt_reg == CNT_W'(OUT_WIDTH - 1));
`ifdef PICASO_ARRAY_PIPE_MSB_FIRST_EN
      assign bit_idx = CNT_W'(OUT_WIDTH - 1) - cnt_reg;
`else
      assign bit_idx = cnt_reg;
`endif

      always_comb begin
        word_next = word_reg;
        if (bit_vld) word_next[bit_idx] = ser_bit[gi][0];
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          cnt_reg <= '0; word_reg <= '0; data_reg <= '0; valid_reg <= 1'b0; ovf_reg <= 1'b0;
        end else if (desClear) begin
          cnt_reg <= '0; word_reg <= '0; valid_reg <= 1'b0; ovf_reg <= 1'b0;
        end else begin
          if (bit_vld) begin
            word_reg <= word_next;
            cnt_reg  <= last ? '0 : cnt_reg + 1'b1;
          end
          // A word completing while the previous one is still unaccepted is dropped.
          if (last) begin
            if (!valid_reg || rowReady[gi]) begin
              data_reg  <= word_next;
              valid_reg <= 1'b1;
            end else begin
              ovf_reg <= 1'b1;
            end
          end else if (valid_reg && rowReady[gi]) begin
            valid_reg <= 1'b0;
          end
        end
      end

      assign rowData[gi*OUT_WIDTH +: OUT_WIDTH] = data_reg;
      assign rowValid[gi]    = valid_reg;
      assign rowOverflow[gi] = ovf_reg;
    end
  endgenerate
endmodule
